// File: rtl/ram_arb_pkg.sv
// Shared definitions for the two-requester RAM arbiter: FSM encodings,
// requester count and the reset value of the round-robin history bit.
package ram_arb_pkg;

    localparam int NUM_REQ = 2;

    // Reset value of last: requester 0 wins the first tie
    localparam logic LAST_RST = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_WRITE   = 3'd1,
        ST_RD_ADDR = 3'd2,
        ST_RD_DATA = 3'd3,
        ST_ACK     = 3'd4
    } state_t;

endpackage

// File: rtl/ram_arbiter_rr_pick2.sv
// Combinational 2-way round-robin selector; with RAM_ARB_LOCK_EN defined a
// held lock pins the grant to the current owner.
module rr_pick2
    import ram_arb_pkg::*;
(
    input  logic [NUM_REQ-1:0] req,
    input  logic               last,
`ifdef RAM_ARB_LOCK_EN
    input  logic               hold,
    input  logic               owner,
`endif
    output logic               gnt,
    output logic               any
);

    always_comb begin
        any = |req;
        gnt = (req == 2'b11) ? ~last : req[1];
`ifdef RAM_ARB_LOCK_EN
        // A locked owner is the only requester that may be granted
        if (hold) begin
            any = req[owner];
            gnt = owner;
        end
`endif
    end

endmodule

// File: rtl/ram_arbiter.sv
// Two-requester arbiter for a single-port RAM with a registered read buffer.
// Optional bus locking for atomic read-modify-write is enabled by RAM_ARB_LOCK_EN.
module ram_arbiter
    import ram_arb_pkg::*;
#(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [1:0]        req,
    input  logic [1:0]        we_in,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata0,
    input  logic [DATA_W-1:0] wdata1,
    input  logic [1:0]        lock,
    output logic [1:0]        ack,
    output logic [DATA_W-1:0] rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic              mem_oe,
    inout  wire  [DATA_W-1:0] mem_data
);

    state_t              state, state_nxt;
    logic                gnt_q, last_q, we_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [DATA_W-1:0]   wdata_q, rdata_q;
    logic                pick_gnt, pick_any, pick_we;
    logic                drive;

`ifdef RAM_ARB_LOCK_EN
    logic owner_valid, owner_q, hold;
    assign hold = owner_valid & lock[owner_q];
`else
    logic unused_lock;
    assign unused_lock = ^lock;
`endif

    rr_pick2 u_pick (
        .req  (req),
        .last (last_q),
`ifdef RAM_ARB_LOCK_EN
        .hold (hold),
        .owner(owner_q),
`endif
        .gnt  (pick_gnt),
        .any  (pick_any)
    );

    assign pick_we = we_in[pick_gnt];

    always_ff @(posedge clk) begin
        if (reset)
            state <= ST_IDLE;
        else
            state <= state_nxt;
    end

    // Command latch, read capture and round-robin/lock bookkeeping
    always_ff @(posedge clk) begin
        if (reset) begin
            gnt_q   <= 1'b0;
            last_q  <= LAST_RST;
            addr_q  <= '0;
            we_q    <= 1'b0;
            wdata_q <= '0;
            rdata_q <= '0;
`ifdef RAM_ARB_LOCK_EN
            owner_valid <= 1'b0;
            owner_q     <= 1'b0;
`endif
        end else begin
            case (state)
                ST_IDLE: begin
`ifdef RAM_ARB_LOCK_EN
                    if (owner_valid && !lock[owner_q])
                        owner_valid <= 1'b0;
`endif
                    if (pick_any) begin
                        gnt_q   <= pick_gnt;
                        addr_q  <= pick_gnt ? addr1 : addr0;
                        we_q    <= pick_we;
                        wdata_q <= pick_gnt ? wdata1 : wdata0;
                    end
                end
                ST_RD_DATA: rdata_q <= mem_data;
                ST_ACK: begin
`ifdef RAM_ARB_LOCK_EN
                    // A locked completion keeps history frozen so the owner keeps priority
                    if (lock[gnt_q]) begin
                        owner_valid <= 1'b1;
                        owner_q     <= gnt_q;
                    end else begin
                        last_q <= gnt_q;
                    end
`else
                    last_q <= gnt_q;
`endif
                end
                default: ;
            endcase
        end
    end

    // Bus controls decode from the state register only
    always_comb begin
        state_nxt = state;
        mem_we    = 1'b0;
        mem_oe    = 1'b0;
        drive     = 1'b0;
        ack       = 2'b00;
        case (state)
            ST_IDLE: begin
                if (pick_any)
                    state_nxt = pick_we ? ST_WRITE : ST_RD_ADDR;
            end
            ST_WRITE: begin
                mem_we    = 1'b1;
                drive     = 1'b1;
                state_nxt = ST_ACK;
            end
            ST_RD_ADDR: state_nxt = ST_RD_DATA;
            ST_RD_DATA: begin
                mem_oe    = 1'b1;
                state_nxt = ST_ACK;
            end
            ST_ACK: begin
                ack[gnt_q] = 1'b1;
                state_nxt  = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    assign mem_data = drive ? wdata_q : {DATA_W{1'bz}};
    assign mem_addr = addr_q;
    assign rdata    = rdata_q;

endmodule

// File: tb/tb_ram_arbiter.sv
// Scoreboard bench for ram_arbiter with a behavioural 256x8 buffered RAM.
// Lock expectations follow RAM_ARB_LOCK_EN when it is defined.
module tb_ram_arbiter;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [1:0] req = 2'b00;
    logic [1:0] we_in = 2'b00;
    logic [7:0] addr0 = 8'h00, addr1 = 8'h00;
    logic [7:0] wdata0 = 8'h00, wdata1 = 8'h00;
    logic [1:0] lock = 2'b00;
    logic [1:0] ack;
    logic [7:0] rdata, mem_addr;
    logic       mem_we, mem_oe;
    wire  [7:0] mem_data;

    int tests = 0;
    int fails = 0;
    int cyc = 0;

    typedef struct {
        logic       is_read;
        logic [7:0] data;
        int         due;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];
    logic [7:0] model [256];

    ram_arbiter dut (
        .clk(clk), .reset(reset), .req(req), .we_in(we_in),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .lock(lock), .ack(ack), .rdata(rdata), .mem_addr(mem_addr),
        .mem_we(mem_we), .mem_oe(mem_oe), .mem_data(mem_data)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural RAM: write on we, read buffer reloaded every edge, driven on oe
    logic [7:0] ram [256];
    logic [7:0] rbuf = 8'h00;
    logic       ram_loaded = 1'b0;
    assign mem_data = mem_oe ? rbuf : 8'bz;

    always @(posedge clk) begin
        if (!ram_loaded) begin
            for (int i = 0; i < 256; i++) ram[i] <= 8'(i) ^ 8'h5A;
            ram_loaded <= 1'b1;
        end else begin
            if (mem_we) ram[mem_addr] <= mem_data;
            rbuf <= ram[mem_addr];
        end
    end

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic pushExp(input int id, input exp_t e);
        if (id == 0) q0.push_back(e);
        else q1.push_back(e);
    endtask

    task automatic checkOutput(input int id);
        exp_t e;
        int   sz;
        sz = (id == 0) ? q0.size() : q1.size();
        tests++;
        if (sz == 0) begin
            fails++;
            $display("[TB] FAIL unexpected_ack%0d: got ack=%b, expected none (cycle %0d)", id, ack, cyc);
        end else begin
            e = (id == 0) ? q0.pop_front() : q1.pop_front();
            check($sformatf("ack%0d_cycle", id), cyc, e.due);
            if (e.is_read) check($sformatf("rdata%0d", id), rdata, e.data);
        end
    endtask

    // Monitor: bus invariants each cycle, and scoreboard pop on every ack
    always @(negedge clk) begin
        if (!reset) begin
            check("we_and_oe", int'(mem_we & mem_oe), 0);
            check("ack_onehot", int'($countones(ack) > 1), 0);
            if (ack[0]) checkOutput(0);
            if (ack[1]) checkOutput(1);
        end
    end

    task automatic applyStimulus(input int id, input logic w, input logic [7:0] a, input logic [7:0] d);
        exp_t e;
        bit   done;
        done = 1'b0;
        @(negedge clk);
        req[id]   = 1'b1;
        we_in[id] = w;
        if (id == 0) begin addr0 = a; wdata0 = d; end
        else begin addr1 = a; wdata1 = d; end
        e.is_read = !w;
        e.data    = w ? 8'h00 : model[a];
        e.due     = cyc + (w ? 2 : 3);
        if (w) model[a] = d;
        pushExp(id, e);
        for (int i = 0; i < 10 && !done; i++) begin
            @(negedge clk);
            if (i == 0 && w) begin
                check("write_we", mem_we, 1);
                check("write_bus", mem_data, d);
                check("write_addr", mem_addr, a);
            end
            if (i == 1 && !w) begin
                check("read_oe", mem_oe, 1);
                check("read_addr", mem_addr, a);
            end
            if (i == 1 && w) check("ack_cycle_we", mem_we, 0);
            if (ack[id]) begin
                done    = 1'b1;
                req[id] = 1'b0;
            end
        end
        if (!done) begin
            fails++;
            $display("[TB] FAIL ack_timeout%0d: got no ack, expected ack within 10 cycles", id);
        end
        req[id] = 1'b0;
    endtask

    task automatic waitAcks(input int n, input bit drop, input int bound);
        int cnt;
        cnt = 0;
        for (int i = 0; i < bound && cnt < n; i++) begin
            @(negedge clk);
            if (ack != 2'b00) begin
                cnt++;
                if (drop) req = req & ~ack;
            end
        end
        if (cnt < n) begin
            fails++;
            $display("[TB] FAIL ack_count: got %0d acks, expected %0d", cnt, n);
        end
        req = 2'b00;
    endtask

    task automatic doReset();
        @(negedge clk);
        reset = 1'b1;
        req   = 2'b00;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        exp_t e;
        int   c;
        int   nacks;
        bit   first0;

        for (int i = 0; i < 256; i++) model[i] = 8'(i) ^ 8'h5A;
        doReset();
        check("rst_ack", ack, 0);
        check("rst_we", mem_we, 0);
        check("rst_oe", mem_oe, 0);
        check("rst_addr", mem_addr, 0);
        check("rst_rdata", rdata, 0);

        // Tie after reset: requester 0 first, requester 1 four cycles later
        c = cyc;
        req = 2'b11; we_in = 2'b00; addr0 = 8'h10; addr1 = 8'h20;
        e = '{1'b1, model[8'h10], c + 3}; pushExp(0, e);
        e = '{1'b1, model[8'h20], c + 7}; pushExp(1, e);
        waitAcks(2, 1'b1, 20);

        // Both held: grants alternate 0,1,0,1
        @(negedge clk);
        c = cyc;
        req = 2'b11; we_in = 2'b00; addr0 = 8'h30; addr1 = 8'h40;
        e = '{1'b1, model[8'h30], c + 3};  pushExp(0, e);
        e = '{1'b1, model[8'h40], c + 7};  pushExp(1, e);
        e = '{1'b1, model[8'h30], c + 11}; pushExp(0, e);
        e = '{1'b1, model[8'h40], c + 15}; pushExp(1, e);
        waitAcks(4, 1'b0, 30);

        applyStimulus(0, 1'b1, 8'h10, 8'hA5);
        applyStimulus(0, 1'b0, 8'h10, 8'h00);
        applyStimulus(1, 1'b1, 8'hFF, 8'h3C);
        applyStimulus(0, 1'b0, 8'hFF, 8'h00);

        // Reset in RD_DATA aborts the read without an ack
        @(negedge clk);
        req[0] = 1'b1; we_in[0] = 1'b0; addr0 = 8'h55;
        repeat (2) @(negedge clk);
        check("abort_in_rd_data", mem_oe, 1);
        reset = 1'b1;
        req   = 2'b00;
        @(negedge clk);
        check("abort_ack", ack, 0);
        check("abort_oe", mem_oe, 0);
        check("abort_rdata", rdata, 0);
        check("abort_addr", mem_addr, 0);
        reset = 1'b0;
        repeat (6) @(negedge clk);

        for (int i = 0; i < 300; i++)
            applyStimulus(int'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                          8'($urandom), 8'($urandom));

        // Lock scenario: requester 0 reads then writes 0x20 while requester 1 waits
        applyStimulus(1, 1'b0, 8'h01, 8'h00);
        @(negedge clk);
        c = cyc;
        req = 2'b11; we_in = 2'b00; addr0 = 8'h20; addr1 = 8'h50; lock = 2'b01;
        e = '{1'b1, model[8'h20], c + 3}; pushExp(0, e);
`ifdef RAM_ARB_LOCK_EN
        e = '{1'b1, model[8'h50], c + 10}; pushExp(1, e);
`else
        e = '{1'b1, model[8'h50], c + 7}; pushExp(1, e);
`endif
        nacks  = 0;
        first0 = 1'b1;
        for (int i = 0; i < 30 && nacks < 3; i++) begin
            @(negedge clk);
            if (ack[0]) begin
                nacks++;
                if (first0) begin
                    first0   = 1'b0;
                    we_in[0] = 1'b1;
                    wdata0   = model[8'h20] + 8'h01;
`ifdef RAM_ARB_LOCK_EN
                    e = '{1'b0, 8'h00, c + 6};
`else
                    e = '{1'b0, 8'h00, c + 10};
`endif
                    pushExp(0, e);
                    model[8'h20] = wdata0;
                end else begin
                    req[0] = 1'b0;
                    lock   = 2'b00;
                end
            end
            if (ack[1]) begin
                nacks++;
                req[1] = 1'b0;
            end
        end
        if (nacks < 3) begin
            fails++;
            $display("[TB] FAIL lock_acks: got %0d acks, expected 3", nacks);
        end
        req = 2'b00; lock = 2'b00;
        applyStimulus(1, 1'b0, 8'h20, 8'h00);

        repeat (4) @(negedge clk);
        check("q0_drained", q0.size(), 0);
        check("q1_drained", q1.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
